// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO, optional FWFT via SYNC_FIFO_FWFT_EN
module sync_fifo_param #(
    parameter int DATA_W    = 20,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   data_cnt,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

    // Thresholds outside their legal ranges would make the flags meaningless
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH out of range 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              mem_empty;
    logic              rd_acc;
    logic              wr_acc;
    logic              valid_nxt;
    logic              ov_cond;
    logic              uf_cond;

    // Extra pointer bit distinguishes full from empty; difference is occupancy
    assign data_cnt     = wr_ptr - rd_ptr;
    assign mem_empty    = (data_cnt == '0);
    assign full         = (data_cnt == DEPTH_C);
    assign almost_full  = (data_cnt >= AFULL_C);
    assign almost_empty = (data_cnt <= AEMPTY_C);

`ifdef SYNC_FIFO_FWFT_EN
    // Memory is read whenever the prefetch register is free or being acknowledged
    assign rd_acc    = ~mem_empty & (~valid | rd_en);
    assign valid_nxt = rd_acc | (valid & ~rd_en);
    assign uf_cond   = rd_en & ~valid;
    assign empty     = ~valid;
`else
    // A read needs a stored word; no write-to-read bypass
    assign rd_acc    = rd_en & ~mem_empty;
    assign valid_nxt = rd_acc;
    assign uf_cond   = rd_en & mem_empty;
    assign empty     = mem_empty;
`endif

    // A read in the same cycle frees the slot a write into a full FIFO needs
    assign wr_acc  = wr_en & (~full | rd_acc);
    assign ov_cond = wr_en & full & ~rd_acc;

    // Storage array, intentionally not reset so it maps onto dual-port RAM
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    // Pointers, registered read port and status pulses; clr overrides traffic
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dout      <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr[ADDR_W-1:0]];
            end
            valid     <= valid_nxt;
            overflow  <= ov_cond;
            underflow <= uf_cond;
        end
    end

endmodule
